// File: rtl/fetch_stage.sv
// fetch_stage: MIPS instruction fetch with PC, IF/ID register, redirects, hazards and sticky fetch fault.
module fetch_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          IMEM_WORDS = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        flush,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [25:0] jump_index,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    output logic [31:0] pc,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc4,
    output logic        if_id_valid,
    output logic        fault,
    output logic [31:0] fault_pc,
    output logic [31:0] fetch_count
);
    typedef enum logic {RUN, FAULTED} state_t;
    state_t      state, state_next;
    logic [31:0] pc_next, instr_next, pc4_next, fault_pc_next, count_next;
    logic        valid_next, bad;
    logic [31:0] pc4;
    assign pc4       = pc + 32'd4;
    assign imem_addr = pc;
    assign fault     = state == FAULTED;
    assign bad       = (pc[1:0] != 2'b00) || ({2'b00, pc[31:2]} >= 32'(IMEM_WORDS));
    always_comb begin
        state_next    = state;
        pc_next       = pc;
        instr_next    = if_id_instr;
        pc4_next      = if_id_pc4;
        valid_next    = if_id_valid;
        fault_pc_next = fault_pc;
        count_next    = fetch_count;
        if (state == FAULTED || bad || (stall && flush) || (!stall && (jump || branch_taken || flush))) begin
            instr_next = 32'h0;
            pc4_next   = 32'h0;
            valid_next = 1'b0;
        end
        if (state == RUN && bad) begin
            state_next    = FAULTED;
            fault_pc_next = pc;
        end else if (state == RUN && !stall) begin
            // jump target takes its region bits from the instruction in decode
            pc_next = jump ? {if_id_pc4[31:28], jump_index, 2'b00} : branch_taken ? branch_target : pc4;
            if (!jump && !branch_taken && !flush) begin
                instr_next = imem_instr;
                pc4_next   = pc4;
                valid_next = 1'b1;
                count_next = fetch_count + 32'd1;
            end
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= RUN;
            pc          <= RESET_PC;
            if_id_instr <= 32'h0;
            if_id_pc4   <= 32'h0;
            if_id_valid <= 1'b0;
            fault_pc    <= 32'h0;
            fetch_count <= 32'h0;
        end else begin
            state       <= state_next;
            pc          <= pc_next;
            if_id_instr <= instr_next;
            if_id_pc4   <= pc4_next;
            if_id_valid <= valid_next;
            fault_pc    <= fault_pc_next;
            fetch_count <= count_next;
        end
    end
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed tests of fetch_stage with a behavioural instruction memory (mem[i] = i+1).
module tb_fetch_stage;
    logic        clk = 1'b0;
    logic        rst, stall, flush, branch_taken, jump;
    logic [31:0] branch_target;
    logic [25:0] jump_index;
    logic [31:0] imem_addr, imem_instr, pc, if_id_instr, if_id_pc4, fault_pc, fetch_count;
    logic        if_id_valid, fault;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;
    assign imem_instr = (imem_addr >> 2) + 32'd1;

    fetch_stage dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .jump(jump), .jump_index(jump_index),
        .imem_addr(imem_addr), .imem_instr(imem_instr), .pc(pc),
        .if_id_instr(if_id_instr), .if_id_pc4(if_id_pc4), .if_id_valid(if_id_valid),
        .fault(fault), .fault_pc(fault_pc), .fetch_count(fetch_count)
    );

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        rst = 0; stall = 0; flush = 0; branch_taken = 0; jump = 0;
        branch_target = 32'h0; jump_index = 26'h0;
    endtask

    task automatic do_reset();
        idle(); rst = 1; step(1); rst = 0;
    endtask

    task automatic test_reset();
        idle(); rst = 1; branch_taken = 1; branch_target = 32'h80; step(2); idle();
        checks += 7;
        if (pc !== 32'h0)          begin errors++; $display("FAIL reset_pc got %h exp %h", pc, 32'h0); end
        if (imem_addr !== 32'h0)   begin errors++; $display("FAIL reset_addr got %h exp %h", imem_addr, 32'h0); end
        if (if_id_instr !== 32'h0) begin errors++; $display("FAIL reset_instr got %h exp %h", if_id_instr, 32'h0); end
        if (if_id_pc4 !== 32'h0)   begin errors++; $display("FAIL reset_pc4 got %h exp %h", if_id_pc4, 32'h0); end
        if (if_id_valid !== 1'b0)  begin errors++; $display("FAIL reset_valid got %b exp 0", if_id_valid); end
        if (fault !== 1'b0)        begin errors++; $display("FAIL reset_fault got %b exp 0", fault); end
        if (fetch_count !== 32'h0) begin errors++; $display("FAIL reset_count got %0d exp 0", fetch_count); end
    endtask

    task automatic test_free_run();
        do_reset(); step(4);
        checks += 5;
        if (pc !== 32'h10)          begin errors++; $display("FAIL run_pc got %h exp %h", pc, 32'h10); end
        if (if_id_instr !== 32'h4)  begin errors++; $display("FAIL run_instr got %h exp %h", if_id_instr, 32'h4); end
        if (if_id_pc4 !== 32'h10)   begin errors++; $display("FAIL run_pc4 got %h exp %h", if_id_pc4, 32'h10); end
        if (if_id_valid !== 1'b1)   begin errors++; $display("FAIL run_valid got %b exp 1", if_id_valid); end
        if (fetch_count !== 32'd4)  begin errors++; $display("FAIL run_count got %0d exp 4", fetch_count); end
    endtask

    task automatic test_stall();
        do_reset(); step(2);
        stall = 1; jump = 1; jump_index = 26'h3F; branch_taken = 1; branch_target = 32'h80; step(3);
        checks += 5;
        if (pc !== 32'h8)          begin errors++; $display("FAIL stall_pc got %h exp %h", pc, 32'h8); end
        if (if_id_instr !== 32'h2) begin errors++; $display("FAIL stall_instr got %h exp %h", if_id_instr, 32'h2); end
        if (if_id_pc4 !== 32'h8)   begin errors++; $display("FAIL stall_pc4 got %h exp %h", if_id_pc4, 32'h8); end
        if (if_id_valid !== 1'b1)  begin errors++; $display("FAIL stall_valid got %b exp 1", if_id_valid); end
        if (fetch_count !== 32'd2) begin errors++; $display("FAIL stall_count got %0d exp 2", fetch_count); end
        jump = 0; branch_taken = 0; flush = 1; step(1); idle();
        checks += 3;
        if (pc !== 32'h8)          begin errors++; $display("FAIL stallflush_pc got %h exp %h", pc, 32'h8); end
        if (if_id_instr !== 32'h0) begin errors++; $display("FAIL stallflush_instr got %h exp %h", if_id_instr, 32'h0); end
        if (if_id_valid !== 1'b0)  begin errors++; $display("FAIL stallflush_valid got %b exp 0", if_id_valid); end
    endtask

    task automatic test_branch();
        do_reset(); step(4);
        branch_taken = 1; branch_target = 32'h40; step(1); idle();
        checks += 3;
        if (pc !== 32'h40)         begin errors++; $display("FAIL br_pc got %h exp %h", pc, 32'h40); end
        if (if_id_valid !== 1'b0)  begin errors++; $display("FAIL br_valid got %b exp 0", if_id_valid); end
        if (if_id_pc4 !== 32'h0)   begin errors++; $display("FAIL br_pc4 got %h exp %h", if_id_pc4, 32'h0); end
        step(1);
        checks += 4;
        if (if_id_pc4 !== 32'h44)   begin errors++; $display("FAIL br_next_pc4 got %h exp %h", if_id_pc4, 32'h44); end
        if (if_id_instr !== 32'h11) begin errors++; $display("FAIL br_next_instr got %h exp %h", if_id_instr, 32'h11); end
        if (pc !== 32'h44)          begin errors++; $display("FAIL br_next_pc got %h exp %h", pc, 32'h44); end
        if (fetch_count !== 32'd5)  begin errors++; $display("FAIL br_next_count got %0d exp 5", fetch_count); end
    endtask

    task automatic test_jump_and_flush();
        do_reset(); step(8);
        checks += 1;
        if (if_id_pc4 !== 32'h20) begin errors++; $display("FAIL jmp_pre_pc4 got %h exp %h", if_id_pc4, 32'h20); end
        jump = 1; jump_index = 26'h10; branch_taken = 1; branch_target = 32'h80; step(1); idle();
        checks += 3;
        if (pc !== 32'h40)         begin errors++; $display("FAIL jmp_pc got %h exp %h", pc, 32'h40); end
        if (if_id_valid !== 1'b0)  begin errors++; $display("FAIL jmp_valid got %b exp 0", if_id_valid); end
        if (fetch_count !== 32'd8) begin errors++; $display("FAIL jmp_count got %0d exp 8", fetch_count); end
        flush = 1; step(1); idle();
        checks += 4;
        if (pc !== 32'h44)         begin errors++; $display("FAIL flush_pc got %h exp %h", pc, 32'h44); end
        if (if_id_valid !== 1'b0)  begin errors++; $display("FAIL flush_valid got %b exp 0", if_id_valid); end
        if (if_id_instr !== 32'h0) begin errors++; $display("FAIL flush_instr got %h exp %h", if_id_instr, 32'h0); end
        if (fetch_count !== 32'd8) begin errors++; $display("FAIL flush_count got %0d exp 8", fetch_count); end
    endtask

    task automatic test_misaligned();
        do_reset();
        branch_taken = 1; branch_target = 32'h402; step(1); idle();
        checks += 2;
        if (pc !== 32'h402)  begin errors++; $display("FAIL mis_pc got %h exp %h", pc, 32'h402); end
        if (fault !== 1'b0)  begin errors++; $display("FAIL mis_early_fault got %b exp 0", fault); end
        step(1);
        checks += 3;
        if (fault !== 1'b1)        begin errors++; $display("FAIL mis_fault got %b exp 1", fault); end
        if (fault_pc !== 32'h402)  begin errors++; $display("FAIL mis_fault_pc got %h exp %h", fault_pc, 32'h402); end
        if (if_id_valid !== 1'b0)  begin errors++; $display("FAIL mis_valid got %b exp 0", if_id_valid); end
        branch_taken = 1; branch_target = 32'h0; step(2); idle();
        checks += 4;
        if (pc !== 32'h402)        begin errors++; $display("FAIL mis_hold_pc got %h exp %h", pc, 32'h402); end
        if (fault !== 1'b1)        begin errors++; $display("FAIL mis_hold_fault got %b exp 1", fault); end
        if (fault_pc !== 32'h402)  begin errors++; $display("FAIL mis_hold_fault_pc got %h exp %h", fault_pc, 32'h402); end
        if (fetch_count !== 32'd0) begin errors++; $display("FAIL mis_hold_count got %0d exp 0", fetch_count); end
        do_reset();
        checks += 3;
        if (fault !== 1'b0)        begin errors++; $display("FAIL mis_rst_fault got %b exp 0", fault); end
        if (fault_pc !== 32'h0)    begin errors++; $display("FAIL mis_rst_fault_pc got %h exp %h", fault_pc, 32'h0); end
        if (pc !== 32'h0)          begin errors++; $display("FAIL mis_rst_pc got %h exp %h", pc, 32'h0); end
    endtask

    task automatic test_range();
        do_reset();
        branch_taken = 1; branch_target = 32'h3FC; step(1); idle(); step(1);
        checks += 4;
        if (pc !== 32'h400)          begin errors++; $display("FAIL rng_last_pc got %h exp %h", pc, 32'h400); end
        if (if_id_instr !== 32'h100) begin errors++; $display("FAIL rng_last_instr got %h exp %h", if_id_instr, 32'h100); end
        if (fetch_count !== 32'd1)   begin errors++; $display("FAIL rng_last_count got %0d exp 1", fetch_count); end
        if (fault !== 1'b0)          begin errors++; $display("FAIL rng_last_fault got %b exp 0", fault); end
        step(1);
        checks += 4;
        if (fault !== 1'b1)        begin errors++; $display("FAIL rng_fault got %b exp 1", fault); end
        if (fault_pc !== 32'h400)  begin errors++; $display("FAIL rng_fault_pc got %h exp %h", fault_pc, 32'h400); end
        if (pc !== 32'h400)        begin errors++; $display("FAIL rng_pc got %h exp %h", pc, 32'h400); end
        if (if_id_valid !== 1'b0)  begin errors++; $display("FAIL rng_valid got %b exp 0", if_id_valid); end
    endtask

    task automatic test_reset_mid();
        do_reset(); step(3);
        stall = 1; flush = 1; rst = 1; step(1); idle();
        checks += 5;
        if (pc !== 32'h0)          begin errors++; $display("FAIL mid_pc got %h exp %h", pc, 32'h0); end
        if (if_id_instr !== 32'h0) begin errors++; $display("FAIL mid_instr got %h exp %h", if_id_instr, 32'h0); end
        if (if_id_pc4 !== 32'h0)   begin errors++; $display("FAIL mid_pc4 got %h exp %h", if_id_pc4, 32'h0); end
        if (if_id_valid !== 1'b0)  begin errors++; $display("FAIL mid_valid got %b exp 0", if_id_valid); end
        if (fetch_count !== 32'd0) begin errors++; $display("FAIL mid_count got %0d exp 0", fetch_count); end
    endtask

    initial begin
        idle();
        @(negedge clk);
        test_reset();
        test_free_run();
        test_stall();
        test_branch();
        test_jump_and_flush();
        test_misaligned();
        test_range();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
